// File: rtl/hms_pkg.sv
// Shared field limits, field types and the 12/24-hour display conversion.
package hms_pkg;
    localparam int HOURS_PER_DAY = 24;
    localparam int MIN_PER_HR    = 60;
    localparam int SEC_PER_MIN   = 60;

    typedef logic [4:0] hour_t;
    typedef logic [5:0] min_t;
    typedef logic [5:0] sec_t;

    // 24-hour internal hour to the displayed hour; 12-hour mode maps 0 to 12.
    function automatic hour_t hour_to_disp(input hour_t h, input logic mode_24);
        if (mode_24)
            return h;
        if (h == 5'd0)
            return 5'd12;
        if (h > 5'd12)
            return h - 5'd12;
        return h;
    endfunction
endpackage

// File: rtl/seven_seg_decoder.sv
// BCD digit to active-high segments {g,f,e,d,c,b,a}; non-decimal codes blank.
module seven_seg_decoder (
    input  logic [3:0] digit,
    output logic [6:0] seg
);
    always_comb begin
        case (digit)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
    end
endmodule

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV cycles; clr holds the count at 0.
module tick_prescaler #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    output logic tick
);
    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] pcnt_q, pcnt_d;

    always_comb begin
        tick   = !clr && (pcnt_q == LAST);
        pcnt_d = (clr || tick) ? '0 : pcnt_q + W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            pcnt_q <= '0;
        else
            pcnt_q <= pcnt_d;
    end
endmodule

// File: rtl/hms_clock_core.sv
// Hours/minutes/seconds timekeeper with set mode, 12/24-hour display and BCD/segment outputs.
// Define HMS_ALARM_EN to add the hour:minute alarm registers and alarm_hit.
module hms_clock_core
    import hms_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       mode_24,
    input  logic       set_time,
    input  logic       inc_hour,
    input  logic       inc_min,
    input  logic       inc_sec,
    input  logic       alarm_set,
    input  logic       alarm_on,
    output logic [3:0] h10,
    output logic [3:0] h1,
    output logic [3:0] m10,
    output logic [3:0] m1,
    output logic [3:0] s10,
    output logic [3:0] s1,
    output logic [6:0] hour10_seg,
    output logic [6:0] hour1_seg,
    output logic [6:0] min10_seg,
    output logic [6:0] min1_seg,
    output logic [6:0] sec10_seg,
    output logic [6:0] sec1_seg,
    output logic       pm,
    output logic       tick,
    output logic       alarm_hit
);
    localparam hour_t HOUR_MAX = hour_t'(HOURS_PER_DAY - 1);
    localparam min_t  MIN_MAX  = min_t'(MIN_PER_HR - 1);
    localparam sec_t  SEC_MAX  = sec_t'(SEC_PER_MIN - 1);

    hour_t hour_q, hour_d;
    min_t  min_q, min_d;
    sec_t  sec_q, sec_d;
    logic  edit_time;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (set_time),
        .tick    (tick)
    );

`ifdef HMS_ALARM_EN
    hour_t al_hour_q, al_hour_d;
    min_t  al_min_q, al_min_d;
    logic  alarm_hit_q, alarm_hit_d;

    assign edit_time = set_time && !alarm_set;

    always_comb begin
        al_hour_d   = al_hour_q;
        al_min_d    = al_min_q;
        if (set_time && alarm_set) begin
            if (inc_hour) al_hour_d = (al_hour_q == HOUR_MAX) ? '0 : al_hour_q + 5'd1;
            if (inc_min)  al_min_d  = (al_min_q == MIN_MAX) ? '0 : al_min_q + 6'd1;
        end
        // Flagged on the edge that loads the matching time, so hit and time appear together.
        alarm_hit_d = tick && alarm_on && (hour_d == al_hour_q) &&
                      (min_d == al_min_q) && (sec_d == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            al_hour_q   <= '0;
            al_min_q    <= '0;
            alarm_hit_q <= 1'b0;
        end else begin
            al_hour_q   <= al_hour_d;
            al_min_q    <= al_min_d;
            alarm_hit_q <= alarm_hit_d;
        end
    end

    assign alarm_hit = alarm_hit_q;
`else
    logic unused_alarm_inputs;
    assign unused_alarm_inputs = &{1'b0, alarm_set, alarm_on};
    assign edit_time = set_time;
    assign alarm_hit = 1'b0;
`endif

    always_comb begin
        hour_d = hour_q;
        min_d  = min_q;
        sec_d  = sec_q;
        if (edit_time) begin
            // Set mode: each field wraps on its own, no carries.
            if (inc_sec)  sec_d  = (sec_q == SEC_MAX) ? '0 : sec_q + 6'd1;
            if (inc_min)  min_d  = (min_q == MIN_MAX) ? '0 : min_q + 6'd1;
            if (inc_hour) hour_d = (hour_q == HOUR_MAX) ? '0 : hour_q + 5'd1;
        end else if (tick) begin
            sec_d = (sec_q == SEC_MAX) ? '0 : sec_q + 6'd1;
            if (sec_q == SEC_MAX) begin
                min_d = (min_q == MIN_MAX) ? '0 : min_q + 6'd1;
                if (min_q == MIN_MAX)
                    hour_d = (hour_q == HOUR_MAX) ? '0 : hour_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hour_q <= '0;
            min_q  <= '0;
            sec_q  <= '0;
        end else begin
            hour_q <= hour_d;
            min_q  <= min_d;
            sec_q  <= sec_d;
        end
    end

    hour_t            hour_disp;
    logic [5:0][3:0]  dig;
    logic [5:0][6:0]  seg;

    always_comb begin
        hour_disp = hour_to_disp(hour_q, mode_24);
        dig[5]    = 4'(hour_disp / 10);
        dig[4]    = 4'(hour_disp % 10);
        dig[3]    = 4'(min_q / 10);
        dig[2]    = 4'(min_q % 10);
        dig[1]    = 4'(sec_q / 10);
        dig[0]    = 4'(sec_q % 10);
    end

    for (genvar i = 0; i < 6; i++) begin : g_seg
        seven_seg_decoder u_dec (.digit(dig[i]), .seg(seg[i]));
    end

    assign {h10, h1, m10, m1, s10, s1} = dig;
    assign {hour10_seg, hour1_seg, min10_seg, min1_seg, sec10_seg, sec1_seg} = seg;
    assign pm = (hour_q >= hour_t'(12));
endmodule

// File: tb/tb_hms_clock_core.sv
// Directed plus randomized bench for hms_clock_core against a time-of-day-in-seconds model.
module tb_hms_clock_core;
    localparam int TD = 4;
`ifdef HMS_ALARM_EN
    localparam bit ALARM = 1'b1;
`else
    localparam bit ALARM = 1'b0;
`endif

    logic clk = 1'b0, reset_n = 1'b0;
    logic mode_24 = 1'b0, set_time = 1'b0, alarm_set = 1'b0, alarm_on = 1'b0;
    logic inc_hour = 1'b0, inc_min = 1'b0, inc_sec = 1'b0;
    logic [3:0] h10, h1, m10, m1, s10, s1;
    logic [6:0] hour10_seg, hour1_seg, min10_seg, min1_seg, sec10_seg, sec1_seg;
    logic pm, tick, alarm_hit;

    hms_clock_core #(.TICK_DIV(TD)) dut (
        .clk(clk), .reset_n(reset_n), .mode_24(mode_24), .set_time(set_time),
        .inc_hour(inc_hour), .inc_min(inc_min), .inc_sec(inc_sec),
        .alarm_set(alarm_set), .alarm_on(alarm_on),
        .h10(h10), .h1(h1), .m10(m10), .m1(m1), .s10(s10), .s1(s1),
        .hour10_seg(hour10_seg), .hour1_seg(hour1_seg), .min10_seg(min10_seg),
        .min1_seg(min1_seg), .sec10_seg(sec10_seg), .sec1_seg(sec1_seg),
        .pm(pm), .tick(tick), .alarm_hit(alarm_hit)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int tod = 0;          // seconds since midnight
    int pc = 0;           // clk edges since the prescaler last restarted
    int al_h = 0, al_m = 0, hits = 0;
    bit hit_exp = 1'b0;
    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    function automatic int disp_h(int h, bit m24);
        if (m24) return h;
        if (h == 0) return 12;
        if (h > 12) return h - 12;
        return h;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        int h, m, s, dh;
        h = tod / 3600; m = (tod / 60) % 60; s = tod % 60;
        dh = disp_h(h, mode_24);
        chk({tag, ".digits"}, {h10, h1, m10, m1, s10, s1},
            {4'(dh / 10), 4'(dh % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)});
        chk({tag, ".segs"}, {hour10_seg, hour1_seg, min10_seg, min1_seg, sec10_seg, sec1_seg},
            {seg_tab[dh / 10], seg_tab[dh % 10], seg_tab[m / 10], seg_tab[m % 10],
             seg_tab[s / 10], seg_tab[s % 10]});
        chk({tag, ".pm"}, pm, h >= 12);
        chk({tag, ".tick"}, tick, !set_time && (pc % TD == TD - 1));
        chk({tag, ".alarm_hit"}, alarm_hit, hit_exp);
    endtask

    // Apply one clock edge's worth of specified behaviour to the model.
    task automatic model_edge();
        int h, m, s;
        h = tod / 3600; m = (tod / 60) % 60; s = tod % 60;
        hit_exp = 1'b0;
        if (set_time) begin
            pc = 0;
            if (ALARM && alarm_set) begin
                if (inc_hour) al_h = (al_h + 1) % 24;
                if (inc_min)  al_m = (al_m + 1) % 60;
            end else begin
                h = (h + int'(inc_hour)) % 24;
                m = (m + int'(inc_min)) % 60;
                s = (s + int'(inc_sec)) % 60;
                tod = h * 3600 + m * 60 + s;
            end
        end else begin
            pc++;
            if (pc % TD == 0) begin
                tod = (tod + 1) % 86400;
                if (ALARM && alarm_on && tod == al_h * 3600 + al_m * 60) begin
                    hit_exp = 1'b1;
                    hits++;
                end
            end
        end
    endtask

    task automatic cyc(string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic pulse(bit ph, bit pmn, bit ps, string tag);
        inc_hour = ph; inc_min = pmn; inc_sec = ps;
        cyc(tag);
        inc_hour = 1'b0; inc_min = 1'b0; inc_sec = 1'b0;
    endtask

    task automatic set_to(int th, int tm, int ts);
        for (int i = 0; i < 60; i++) begin
            if (tod == th * 3600 + tm * 60 + ts) break;
            pulse(tod / 3600 != th, (tod / 60) % 60 != tm, tod % 60 != ts, "set");
        end
        chk("set_to.reached", tod, th * 3600 + tm * 60 + ts);
    endtask

    task automatic run(int n, string tag);
        repeat (n) cyc(tag);
    endtask

    initial begin
        int hits0;
        // Reset state in 12-hour mode
        #12;
        check_all("reset");
        @(negedge clk);
        reset_n = 1'b1;
        run(TD, "first_tick");
        chk("first_tick.tod", tod, 1);

        // Midnight rollover in 24-hour mode
        mode_24 = 1'b1; set_time = 1'b1;
        set_to(23, 59, 58);
        set_time = 1'b0;
        run(2 * TD, "rollover");
        chk("rollover.tod", tod, 0);

        // Display-only mode change
        set_time = 1'b1;
        set_to(13, 5, 0);
        mode_24 = 1'b0; #1;
        check_all("mode12");
        chk("mode12.h", {h10, h1}, 8'h01);
        cyc("mode12");
        mode_24 = 1'b1; #1;
        check_all("mode24");
        cyc("mode24");

        // Simultaneous set pulses, no carries
        set_to(11, 59, 30);
        pulse(1'b1, 1'b1, 1'b0, "simul");
        chk("simul.tod", tod, 12 * 3600 + 30);

        // Alarm editing (time edits instead when the alarm is compiled out)
        alarm_set = 1'b1;
        repeat (7) pulse(1'b1, 1'b0, 1'b0, "al_hour");
        repeat (30) pulse(1'b0, 1'b1, 1'b0, "al_min");
        pulse(1'b0, 1'b0, 1'b1, "al_sec");
        alarm_set = 1'b0;
        set_to(7, 29, 59);
        alarm_on = 1'b1; set_time = 1'b0;
        hits0 = hits;
        run(TD + 2, "alarm_on");
        chk("alarm_on.hits", hits - hits0, ALARM ? 1 : 0);
        set_time = 1'b1;
        set_to(7, 29, 59);
        alarm_on = 1'b0; set_time = 1'b0;
        run(TD + 2, "alarm_off");

        // Asynchronous reset mid-prescale
        set_time = 1'b1; mode_24 = 1'b0;
        set_to(5, 10, 20);
        set_time = 1'b0;
        run(2, "prereset");
        #2 reset_n = 1'b0;
        tod = 0; pc = 0; al_h = 0; al_m = 0; hit_exp = 1'b0;
        #1;
        check_all("async_reset");
        chk("async_reset.h", {h10, h1, m10, m1, s10, s1}, 24'h120000);
        @(negedge clk);
        reset_n = 1'b1;
        run(TD + 1, "post_reset");

        // Randomized set/run mix
        for (int k = 0; k < 40; k++) begin
            mode_24  = 1'($urandom_range(0, 1));
            alarm_on = 1'($urandom_range(0, 1));
            set_time = ($urandom_range(0, 2) == 0);
            if (set_time) begin
                alarm_set = ($urandom_range(0, 3) == 0);
                repeat ($urandom_range(1, 12))
                    pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), "rnd_set");
                alarm_set = 1'b0;
            end else begin
                run($urandom_range(1, 3 * TD), "rnd_run");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hms_clock_core.md
# hms_clock_core

Parametrised hours/minutes/seconds timekeeping core: successor of the fixed 12-hour clock, with an internal tick prescaler, run-time 12/24-hour display mode, a per-field set mode and a compile-time alarm. Time is held internally as 24-hour binary fields. The core drives six BCD digits, six seven-segment outputs through `seven_seg_decoder`, and a PM flag for the board display layer.

## Interface
- `TICK_DIV`, 100_000_000: `clk` cycles per second tick; must be ≥ 2.
- `clk` input 1: system clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `mode_24` input 1: 1 = 24-hour display, 0 = 12-hour display. Level-sampled every cycle.
- `set_time` input 1: level; when high, time is frozen and editable.
- `inc_hour`, `inc_min`, `inc_sec` input 1 each: single-cycle increment pulses, debounced upstream. Honoured only while `set_time` = 1.
- `alarm_set` input 1: level; with `set_time`, redirects `inc_hour`/`inc_min` to the alarm registers.
- `alarm_on` input 1: alarm enable.
- `h10`, `h1`, `m10`, `m1`, `s10`, `s1` output 4 each: BCD display digits.
- `hour10_seg` … `sec1_seg` output 7 each: decoded segments, one per digit.
- `pm` output 1: 1 when internal hour ≥ 12, in both modes.
- `tick` output 1: one-cycle pulse on each second advance.
- `alarm_hit` output 1: one-cycle alarm pulse.

## Operation
- State: `hour` (5b, 0–23), `min` (6b, 0–59), `sec` (6b, 0–59), prescaler `pcnt` (`$clog2(TICK_DIV)` bits).
- Run (`set_time` = 0):
  - `pcnt` counts 0…`TICK_DIV-1`; at terminal count it wraps to 0 and `tick` = 1.
  - On `tick`: sec+1; 59→0 carries into min; min 59→0 carries into hour; hour 23→0.
- Set (`set_time` = 1):
  - `pcnt` is held at 0 and `tick` = 0.
  - `inc_sec` wraps sec 59→0; `inc_min` wraps min 59→0; `inc_hour` wraps hour 23→0.
  - No carry between fields.
  - Simultaneous pulses on different fields all apply in the same cycle.
- Display (combinational from registers):
  - 24-hour mode: hour shown as 00–23.
  - 12-hour mode: hour 0 → 12; 1–12 → unchanged; 13–23 → hour−12.
  - `pm` = hour ≥ 12 in both modes.
  - Minutes and seconds: BCD split by /10, %10.
- Mode change is display-only. No register changes, and there are no glitches beyond the single combinational update.

## Timing
- Reset values:
  - hour = min = sec = 0 and `pcnt` = 0.
  - `tick` = 0, `alarm_hit` = 0, `pm` = 0.
  - Digits show 12:00:00 when `mode_24` = 0 and 00:00:00 when `mode_24` = 1.
- First `tick` comes `TICK_DIV` cycles after reset release. Ticks are then spaced exactly `TICK_DIV` cycles apart.
- Register updates are visible on the digit outputs in the cycle after the `tick` or `inc_*` edge. Segment outputs carry no extra latency.
- Leaving set mode restarts the prescaler from 0, so the next `tick` comes `TICK_DIV` cycles later.
- Reset asserted mid-count clears all state immediately, without waiting for a clock edge.

## Configuration
- `HMS_ALARM_EN` defined:
  - Adds alarm registers `al_hour` (0–23) and `al_min` (0–59), both reset to 0.
  - While `set_time` = 1 and `alarm_set` = 1, `inc_hour`/`inc_min` edit the alarm registers instead of the time. Time is unchanged and `inc_sec` is ignored.
  - `alarm_hit` pulses for one cycle, coincident with the register update, when a run-mode `tick` makes time equal to `al_hour:al_min:00` and `alarm_on` = 1.
  - No hit is generated while in set mode.
- `HMS_ALARM_EN` undefined:
  - Alarm registers are absent.
  - `alarm_set` and `alarm_on` are ignored.
  - `alarm_hit` is tied to 0.
  - Ports remain present in both builds.

## Structure
- Shared package `hms_pkg`:
  - Field limits `HOURS_PER_DAY`, `MIN_PER_HR`, `SEC_PER_MIN`.
  - Typedef widths `hour_t`/`min_t`/`sec_t`.
  - 12/24 conversion function `hour_to_disp`.
- One sub-module, `tick_prescaler` (parameter `TICK_DIV`; ports `clk`, `reset_n`, `clr`, `tick`), cleared by `set_time`.
- Six `seven_seg_decoder` instances, one per digit.

## Test plan
- Reset with `TICK_DIV` = 4, `mode_24` = 0 → digits 12:00:00, `pm` = 0; first `tick` at cycle 4 → 12:00:01.
- Set to 23:59:58 (`mode_24` = 1), release `set_time`, run 2 ticks → 23:59:59, then 00:00:00, `pm` 1→0.
- Time 13:05:00 → toggle `mode_24` 1→0 → display reads 01:05:00, `pm` = 1, registers unchanged.
- In set mode, pulse `inc_min` and `inc_hour` together at 11:59:30 → 12:00:30 with no seconds or minutes carry; `pm` = 1.
- `HMS_ALARM_EN`: alarm 07:30, `alarm_on` = 1, time 07:29:59 → one-cycle `alarm_hit` on the tick to 07:30:00. With `alarm_on` = 0 → no pulse.
- Assert `reset_n` low mid-prescale at 05:10:20 → outputs immediately show 12:00:00 with `tick` = 0. After release, `tick` comes `TICK_DIV` cycles later.
